s_to_a_fix_conv: RTL and testbench

//  Scalar-to-address conversion unit: reverse direction of the scalar constant generator.

---
 rtl/cray_float_pkg.sv | 38 +++
 rtl/s2a_iter_shifter.sv | 55 +++++
 rtl/s_to_a_fix_conv.sv | 160 ++++++++++++++++
 tb/tb_s_to_a_fix_conv.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cray_float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cray_float_pkg
//  Description : Shared definitions for the scalar-to-address conversion
//                path: Cray float field positions, exponent bias, conversion
//                mode encodings and the converter FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package cray_float_pkg;

   // Field positions inside a 64-bit S-register float word
   localparam int SIGN_BIT = 63;
   localparam int EXP_MSB  = 62;
   localparam int EXP_LSB  = 48;
   localparam int COEF_MSB = 47;
   localparam int COEF_LSB = 0;

   localparam logic [14:0] EXP_BIAS = 15'o40000;

   // Conversion modes
   localparam logic [1:0] S2A_TRUNC    = 2'b00;
   localparam logic [1:0] S2A_FIX_WRAP = 2'b01;
   localparam logic [1:0] S2A_FIX_SAT  = 2'b10;
   localparam logic [1:0] S2A_EXP      = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } s2a_state_t;

   // Unbiased exponent as a 16-bit signed value
   function automatic logic signed [15:0] unbias_exp(input logic [14:0] exp_field);
      return $signed({1'b0, exp_field}) - $signed({1'b0, EXP_BIAS});
   endfunction

endpackage
`default_nettype wire

// File: rtl/s2a_iter_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : s2a_iter_shifter
//  Description : Iterative right shifter used to denormalize the coefficient.
//                Shifts by at most SHIFT_STEP bits per step cycle until the
//                remaining count is exhausted.
//  Ports       : clk, rst_n     clock / async active-low reset
//                i_load         load i_data and shift count i_sh
//                i_data [47:0]  coefficient to denormalize
//                i_sh   [5:0]   total right-shift amount
//                i_step         perform one shift step
//                o_low  [23:0]  low 24 bits of the shift register
//                o_done         the current step empties the remaining count
//  Revision    : 1.0  initial release
// ============================================================================
module s2a_iter_shifter #(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic [47:0] i_data,
   input  logic [5:0]  i_sh,
   input  logic        i_step,
   output logic [23:0] o_low,
   output logic        o_done
);

   localparam logic [5:0] c_STEP = 6'(SHIFT_STEP);

   logic [47:0] r_data;
   logic [5:0]  r_rem;
   logic [5:0]  w_amt;

   assign w_amt  = (r_rem < c_STEP) ? r_rem : c_STEP;
   // Asserted during the final step so the FSM leaves SHIFT without an
   // extra idle cycle.
   assign o_done = (r_rem <= c_STEP);
   assign o_low  = r_data[23:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
         r_rem  <= '0;
      end else if (i_load) begin
         r_data <= i_data;
         r_rem  <= i_sh;
      end else if (i_step) begin
         r_data <= r_data >> w_amt;
         r_rem  <= r_rem - w_amt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/s_to_a_fix_conv.sv
`default_nettype none
// ============================================================================
//  Module      : s_to_a_fix_conv
//  Description : Scalar-to-address conversion. Converts a 64-bit Cray float
//                S word into a 24-bit A value: raw truncation, float-to-fix
//                (wrap or saturate on overflow) or unbiased exponent.
//  Ports       : clk, rst_n          clock / async active-low reset
//                i_start             request strobe (accepted when !o_busy)
//                i_mode [1:0]        conversion mode
//                i_sj   [63:0]       operand
//                o_busy              conversion in progress
//                o_valid             one-cycle result pulse
//                o_result [23:0]     result, held until next o_valid
//                o_ovf               magnitude not representable in 24b
//                o_range_err         exponent field out of normal range
//  Revision    : 1.0  initial release
// ============================================================================
module s_to_a_fix_conv
   import cray_float_pkg::*;
#(
   parameter int SHIFT_STEP = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [1:0]  i_mode,
   input  logic [63:0] i_sj,
   output logic        o_busy,
   output logic        o_valid,
   output logic [23:0] o_result,
   output logic        o_ovf,
   output logic        o_range_err
);

   s2a_state_t         r_state;
   logic               r_sign;
   logic [1:0]         r_mode;
   logic signed [15:0] r_e;
   logic               r_coef_zero;
   logic               r_rerr_pend;
   logic               r_busy;
   logic               r_valid;
   logic [23:0]        r_result;
   logic               r_ovf;
   logic               r_range_err;

   logic [14:0]        w_exp;
   logic [47:0]        w_coef;
   logic signed [15:0] w_e;
   logic               w_accept;
   logic               w_is_fix;
   logic               w_go_shift;
   logic [5:0]         w_sh;
   logic               w_rerr;
   logic [23:0]        w_low;
   logic               w_sh_done;
   logic [23:0]        w_mag;
   logic [23:0]        w_result;
   logic               w_ovf;

   assign w_exp    = i_sj[EXP_MSB:EXP_LSB];
   assign w_coef   = i_sj[COEF_MSB:COEF_LSB];
   assign w_e      = unbias_exp(w_exp);
   assign w_accept = i_start && !r_busy && (r_state == ST_IDLE);
   assign w_is_fix = (i_mode == S2A_FIX_WRAP) || (i_mode == S2A_FIX_SAT);
   assign w_go_shift = w_is_fix && (w_e >= 16'sd1) && (w_e <= 16'sd23);
   // Only meaningful for 1 <= e <= 23, where 48-e fits in 6 bits, so the
   // low bits of e are sufficient.
   assign w_sh   = w_go_shift ? (6'd48 - w_e[5:0]) : 6'd0;
   assign w_rerr = ((w_exp[14:13] == 2'b11) || (w_exp[14:13] == 2'b00)) && (i_sj != 64'd0);

   s2a_iter_shifter #(
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_accept),
      .i_data (w_coef),
      .i_sh   (w_sh),
      .i_step (r_state == ST_SHIFT),
      .o_low  (w_low),
      .o_done (w_sh_done)
   );

   // Result formation from the captured operand and the shifted coefficient.
   // For 1 <= e <= 23 the shifted magnitude is below 2^23.
   always_comb begin
      w_result = '0;
      w_ovf    = 1'b0;
      w_mag    = {1'b0, w_low[22:0]};
      case (r_mode)
         S2A_TRUNC: w_result = w_low;
         S2A_EXP:   w_result = {{8{r_e[15]}}, r_e};
         default: begin
            if (!r_coef_zero && (r_e >= 16'sd24)) begin
               w_ovf = 1'b1;
               if (r_mode == S2A_FIX_SAT)
                  w_result = r_sign ? 24'h800000 : 24'h7FFFFF;
            end else if (!r_coef_zero && (r_e >= 16'sd1)) begin
               w_result = r_sign ? -w_mag : w_mag;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_sign      <= 1'b0;
         r_mode      <= S2A_TRUNC;
         r_e         <= '0;
         r_coef_zero <= 1'b0;
         r_rerr_pend <= 1'b0;
         r_busy      <= 1'b0;
         r_valid     <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Busy stays up through the o_valid cycle, so a start in
               // that cycle is ignored.
               if (r_valid)
                  r_busy <= 1'b0;
               if (w_accept) begin
                  r_busy      <= 1'b1;
                  r_sign      <= i_sj[SIGN_BIT];
                  r_mode      <= i_mode;
                  r_e         <= w_e;
                  r_coef_zero <= (w_coef == 48'd0);
                  r_rerr_pend <= w_rerr;
                  r_state     <= w_go_shift ? ST_SHIFT : ST_FINISH;
               end
            end
            ST_SHIFT: begin
               if (w_sh_done)
                  r_state <= ST_FINISH;
            end
            ST_FINISH: begin
               r_valid     <= 1'b1;
               r_result    <= w_result;
               r_ovf       <= w_ovf;
               r_range_err <= r_rerr_pend;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_valid     = r_valid;
   assign o_result    = r_result;
   assign o_ovf       = r_ovf;
   assign o_range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_s_to_a_fix_conv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s_to_a_fix_conv
//  Description : Self-checking bench for s_to_a_fix_conv. Expected results
//                are queued when a request is driven and compared when the
//                DUT pulses o_valid. A second instance with SHIFT_STEP=1
//                covers the slow-shift latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_s_to_a_fix_conv;

   typedef struct {
      string       name;
      logic [1:0]  m;
      logic [63:0] sj;
      logic [23:0] res;
      logic        ovf;
      logic        rerr;
      int          lat;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        i_start, start1;
   logic [1:0]  i_mode, mode1;
   logic [63:0] i_sj, sj1;
   logic        o_busy, busy1;
   logic        o_valid, valid1;
   logic [23:0] o_result, result1;
   logic        o_ovf, ovf1;
   logic        o_range_err, rerr1;

   int   n_chk;
   int   n_fail;
   vec_t sb[$];

   localparam logic [63:0] c_ONE    = 64'o0400014000000000000000;
   localparam logic [63:0] c_NEG2P5 = {1'b1, 15'o40002, 48'hA000_0000_0000};

   s_to_a_fix_conv #(.SHIFT_STEP(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_sj(i_sj),
      .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result), .o_ovf(o_ovf),
      .o_range_err(o_range_err)
   );

   s_to_a_fix_conv #(.SHIFT_STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start1), .i_mode(mode1), .i_sj(sj1),
      .o_busy(busy1), .o_valid(valid1), .o_result(result1), .o_ovf(ovf1),
      .o_range_err(rerr1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input string nm, input logic [1:0] m, input logic [63:0] sj,
                               input logic [23:0] r, input logic o, input logic re, input int l);
      vec_t v;
      v.name = nm; v.m = m; v.sj = sj; v.res = r; v.ovf = o; v.rerr = re; v.lat = l;
      return v;
   endfunction

   // Arithmetic reference for arbitrary operands (SHIFT_STEP given by step)
   function automatic vec_t model(input logic [1:0] m, input logic [63:0] sj, input int step);
      vec_t        v;
      logic        sign;
      logic [14:0] ex;
      logic [47:0] coef;
      logic [47:0] mag;
      int          e;
      sign = sj[63]; ex = sj[62:48]; coef = sj[47:0];
      e = int'(ex) - 16384;
      v = mk("rand", m, sj, 24'h0, 1'b0, 1'b0, 2);
      v.rerr = ((ex >= 15'o60000) || (ex < 15'o20000)) && (sj != 64'd0);
      if ((m == 2'd1 || m == 2'd2) && e >= 1 && e <= 23)
         v.lat = 2 + (48 - e + step - 1) / step;
      case (m)
         2'd0: v.res = sj[23:0];
         2'd3: v.res = 24'(e);
         default: begin
            if (coef != 0 && e >= 24) begin
               v.ovf = 1'b1;
               if (m == 2'd2) v.res = sign ? 24'h800000 : 24'h7FFFFF;
            end else if (coef != 0 && e >= 1) begin
               mag = coef >> (48 - e);
               v.res = sign ? 24'(-mag) : 24'(mag);
            end
         end
      endcase
      return v;
   endfunction

   // Issue one request on the main instance and wait for o_valid (bounded).
   task automatic drive0(input logic [1:0] m, input logic [63:0] sj, output int lat);
      @(posedge clk); #1;
      i_mode = m; i_sj = sj; i_start = 1'b1; lat = 0;
      do begin
         @(posedge clk); #1;
         i_start = 1'b0;
         lat++;
      end while (!o_valid && lat < 200);
      if (!o_valid) lat = -1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; i_sj = '0;
      start1 = 1'b0; mode1 = 2'd0; sj1 = '0;
      #12;
      n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
      n_chk++; if (o_result !== 24'h0) begin n_fail++; $display("FAIL reset_result got %h want 000000", o_result); end
      n_chk++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
      n_chk++; if (o_range_err !== 1'b0) begin n_fail++; $display("FAIL reset_rerr got %b want 0", o_range_err); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_spec_cases;
      vec_t v[15];
      vec_t x;
      int   lat;
      v[0]  = mk("trunc",      2'd0, 64'h0123_4567_89AB_CDEF, 24'hABCDEF, 1'b0, 1'b1, 2);
      v[1]  = mk("fix_one",    2'd1, c_ONE, 24'h000001, 1'b0, 1'b0, 8);
      v[2]  = mk("fix_neg2p5", 2'd1, c_NEG2P5, 24'hFFFFFE, 1'b0, 1'b0, 8);
      v[3]  = mk("sat_pos",    2'd2, {1'b0, 15'o40037, 48'h8000_0000_0000}, 24'h7FFFFF, 1'b1, 1'b0, 2);
      v[4]  = mk("sat_neg",    2'd2, {1'b1, 15'o40037, 48'h8000_0000_0000}, 24'h800000, 1'b1, 1'b0, 2);
      v[5]  = mk("wrap_ovf",   2'd1, {1'b0, 15'o40037, 48'h8000_0000_0000}, 24'h000000, 1'b1, 1'b0, 2);
      v[6]  = mk("half",       2'd1, 64'o0400004000000000000000, 24'h000000, 1'b0, 1'b0, 2);
      v[7]  = mk("range_hi",   2'd1, {1'b0, 15'o60000, 48'h8000_0000_0000}, 24'h000000, 1'b1, 1'b1, 2);
      v[8]  = mk("zero_word",  2'd1, 64'd0, 24'h000000, 1'b0, 1'b0, 2);
      v[9]  = mk("exp_pos",    2'd3, {1'b0, 15'o40037, 48'h8000_0000_0000}, 24'd31, 1'b0, 1'b0, 2);
      v[10] = mk("exp_neg",    2'd3, {1'b0, 15'd0, 48'h1}, 24'hFFC000, 1'b0, 1'b1, 2);
      v[11] = mk("neg_zero",   2'd1, {1'b1, 15'o40001, 48'h1}, 24'h000000, 1'b0, 1'b0, 8);
      v[12] = mk("sat_m2p23",  2'd2, {1'b1, 15'o40030, 48'h8000_0000_0000}, 24'h800000, 1'b1, 1'b0, 2);
      v[13] = mk("max_fit",    2'd1, {1'b0, 15'o40027, 48'hFFFF_FFFF_FFFF}, 24'h7FFFFF, 1'b0, 1'b0, 6);
      v[14] = mk("coef0_big",  2'd2, {1'b0, 15'o40037, 48'h0}, 24'h000000, 1'b0, 1'b0, 2);
      for (int i = 0; i < 15; i++) begin
         sb.push_back(v[i]);
         drive0(v[i].m, v[i].sj, lat);
         x = sb.pop_front();
         n_chk++; if (o_result !== x.res) begin n_fail++; $display("FAIL %s result got %h want %h", x.name, o_result, x.res); end
         n_chk++; if (o_ovf !== x.ovf) begin n_fail++; $display("FAIL %s ovf got %b want %b", x.name, o_ovf, x.ovf); end
         n_chk++; if (o_range_err !== x.rerr) begin n_fail++; $display("FAIL %s rerr got %b want %b", x.name, o_range_err, x.rerr); end
         n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", x.name, lat, x.lat); end
      end
   endtask

   task automatic test_random;
      vec_t        x;
      logic [1:0]  m;
      logic [63:0] sj;
      logic [14:0] ex;
      int          lat;
      for (int i = 0; i < 16; i++) begin
         m  = 2'($urandom_range(0, 3));
         ex = 15'(int'(15'o40000) + $urandom_range(0, 40) - 8);
         sj = {1'($urandom), ex, 16'($urandom), 32'($urandom)};
         sb.push_back(model(m, sj, 8));
         drive0(m, sj, lat);
         x = sb.pop_front();
         n_chk++; if (o_result !== x.res) begin n_fail++; $display("FAIL rand%0d result got %h want %h (sj %h m %0d)", i, o_result, x.res, sj, m); end
         n_chk++; if (o_ovf !== x.ovf) begin n_fail++; $display("FAIL rand%0d ovf got %b want %b", i, o_ovf, x.ovf); end
         n_chk++; if (o_range_err !== x.rerr) begin n_fail++; $display("FAIL rand%0d rerr got %b want %b", i, o_range_err, x.rerr); end
         n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, x.lat); end
      end
   endtask

   // A start pulsed while busy must be dropped: one o_valid, first operand.
   task automatic test_busy_ignore;
      int nv, vlat, cyc;
      logic [23:0] vres;
      nv = 0; vlat = -1; vres = '0; cyc = 0;
      @(posedge clk); #1;
      i_mode = 2'd1; i_sj = c_ONE; i_start = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            i_start = 1'b0;
            n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept got %b want 1", o_busy); end
         end
         if (cyc == 3) begin i_mode = 2'd2; i_sj = {1'b0, 15'o40037, 48'h8000_0000_0000}; i_start = 1'b1; end
         if (cyc == 5) i_start = 1'b0;
         if (cyc == 8) begin
            n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_valid got %b want 1", o_busy); end
         end
         if (cyc == 9) begin
            n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_valid got %b want 0", o_busy); end
         end
         if (o_valid) begin
            nv++;
            if (vlat < 0) begin vlat = cyc; vres = o_result; end
         end
      end
      n_chk++; if (nv != 1) begin n_fail++; $display("FAIL busy_valid_count got %0d want 1", nv); end
      n_chk++; if (vlat != 8) begin n_fail++; $display("FAIL busy_latency got %0d want 8", vlat); end
      n_chk++; if (vres !== 24'h000001) begin n_fail++; $display("FAIL busy_result got %h want 000001", vres); end
   endtask

   task automatic test_reset_abort;
      vec_t x;
      int   nv, lat;
      @(posedge clk); #1;
      i_mode = 2'd1; i_sj = c_ONE; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b want 1", o_busy); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", o_busy); end
      n_chk++; if (o_result !== 24'h0) begin n_fail++; $display("FAIL abort_result got %h want 000000", o_result); end
      n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", o_valid); end
      #3;
      rst_n = 1'b1;
      nv = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (o_valid) nv++;
      end
      n_chk++; if (nv != 0) begin n_fail++; $display("FAIL abort_no_valid got %0d want 0", nv); end
      sb.push_back(mk("after_abort", 2'd1, c_NEG2P5, 24'hFFFFFE, 1'b0, 1'b0, 8));
      drive0(2'd1, c_NEG2P5, lat);
      x = sb.pop_front();
      n_chk++; if (o_result !== x.res) begin n_fail++; $display("FAIL %s result got %h want %h", x.name, o_result, x.res); end
      n_chk++; if (o_ovf !== x.ovf) begin n_fail++; $display("FAIL %s ovf got %b want %b", x.name, o_ovf, x.ovf); end
      n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", x.name, lat, x.lat); end
   endtask

   task automatic test_step1;
      vec_t x;
      int   lat;
      sb.push_back(mk("step1_one", 2'd1, c_ONE, 24'h000001, 1'b0, 1'b0, 49));
      @(posedge clk); #1;
      mode1 = 2'd1; sj1 = c_ONE; start1 = 1'b1; lat = 0;
      do begin
         @(posedge clk); #1;
         start1 = 1'b0;
         lat++;
      end while (!valid1 && lat < 200);
      if (!valid1) lat = -1;
      x = sb.pop_front();
      n_chk++; if (result1 !== x.res) begin n_fail++; $display("FAIL %s result got %h want %h", x.name, result1, x.res); end
      n_chk++; if (ovf1 !== x.ovf) begin n_fail++; $display("FAIL %s ovf got %b want %b", x.name, ovf1, x.ovf); end
      n_chk++; if (rerr1 !== x.rerr) begin n_fail++; $display("FAIL %s rerr got %b want %b", x.name, rerr1, x.rerr); end
      n_chk++; if (lat != x.lat) begin n_fail++; $display("FAIL %s latency got %0d want %0d", x.name, lat, x.lat); end
      n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL step1_busy_in_valid got %b want 1", busy1); end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_spec_cases();
      test_random();
      test_busy_ignore();
      test_reset_abort();
      test_step1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
